servo_motion_ctrl: RTL and testbench
====================================

// Module: servo_motion_ctrl
// PURPOSE
//  Motion sequencer in front of the servo PWM driver. Arbitrates angle
//  commands from two requesters: req0 = vision tracker, req1 = manual
//  override (higher priority). It ramps the driver's angle_setting toward
//  the granted target by a bounded step once per PWM frame, then holds
//  for a settle interval. It owns the driver's angle input exclusively.
// PARAMETERS
//  FRAME_CYC    1_000_001  clk cycles per PWM frame (matches driver 0..1_000_000 count)
//  STEP         2          max degrees moved per frame (1..255)
//  ANGLE_MIN    1          lowest commanded angle (driver idles pwm at 0)
//  ANGLE_MAX    179        highest commanded angle (driver idles pwm at >=180)
//  INIT_ANGLE   90         angle_setting/target after reset
//  HOLD_FRAMES  5          settle frames after arrival before next req0 grant
// PORTS
//  clk            in   1  system clock, 50 MHz
//  rst_n          in   1  async active-low reset
//  req0_valid     in   1  tracker command valid; hold until accepted
//  req0_angle     in   8  tracker target angle, degrees
//  req0_ready     out  1  tracker command accepted this cycle when valid&ready
//  req1_valid     in   1  override command valid; hold until accepted
//  req1_angle     in   8  override target angle, degrees
//  req1_ready     out  1  override command accepted this cycle when valid&ready
//  angle_setting  out  8  angle to driver; changes only on frame tick
//  busy           out  1  high in MOVE or HOLD
//  done           out  1  1-cycle pulse on arrival at target
//  grant_id       out  1  source of current target (0=req0, 1=req1)
// BEHAVIOUR
//  Reset (async, rst_n low): state=IDLE, frame cnt=0, angle_setting=target=INIT_ANGLE,
//   busy=0, done=0, grant_id=0. Both readies are forced 0 while rst_n is low.
//  Frame counter: free-running 0..FRAME_CYC-1, wraps to 0. tick = (cnt==FRAME_CYC-1).
//   It is never restarted by a grant, so the first step comes 1..FRAME_CYC cycles after grant.
//  Readies are combinational from state/inputs:
//   req1_ready = 1 in IDLE, MOVE and HOLD.
//   req0_ready = (state==IDLE) & ~req1_valid. req1 wins on simultaneous valid.
//  Accept: on valid&ready, the clamped angle is loaded into target on the next edge,
//   grant_id is set, and state becomes MOVE. Clamp: <ANGLE_MIN -> ANGLE_MIN;
//   >ANGLE_MAX -> ANGLE_MAX.
//  States:
//   IDLE: wait for a grant.
//   MOVE: on tick, if angle==target -> done=1 for one cycle, hold_cnt=0, go to HOLD.
//    Otherwise angle += sign(diff)*min(STEP,|diff|). There is no overshoot, and
//    arrival is detected on the following tick.
//   HOLD: hold_cnt++ on each tick; at HOLD_FRAMES ticks -> IDLE.
//  Preemption: a req1 accept in MOVE/HOLD retargets, goes to MOVE, and emits no done.
//   The angle continues from its current value, with no jump.
//  A target equal to the current angle is still accepted -> MOVE -> done on next tick.
//  Arithmetic: diff computed in 9-bit signed; angle_setting always in [ANGLE_MIN,ANGLE_MAX]
//   after the first grant. INIT_ANGLE must lie in that range.
//  Reset mid-move: the angle returns immediately to INIT_ANGLE and any pending done is dropped.
//  busy = (state!=IDLE). done never coincides with an accept.
// TESTING  (sim with FRAME_CYC=10, STEP=2, HOLD_FRAMES=2)
//  1 Reset -> angle_setting=90, busy=0, done=0, req0_ready=1 once rst_n=1 and req1_valid=0.
//  2 req0 angle=95 -> angle 92,94,95 on successive ticks; done pulses on the 4th tick;
//    IDLE 2 ticks later; grant_id=0.
//  3 req0 and req1 valid in the same cycle (60 vs 120) -> req1 granted, req0_ready=0;
//    req0 is accepted only after the return to IDLE.
//  4 req0 to 150, then req1 to 100 at angle 110 -> no done; ramp 108..100; done once;
//    grant_id=1.
//  5 Clamp: req0 angle=0 -> target 1; req1 angle=200 -> target 179; the driver never sees 0 or >=180.
//  6 Assert rst_n low mid-ramp at angle 70 -> immediately angle_setting=90, busy=0, readies=0.

Source files
------------

// File: rtl/servo_motion_ctrl_if.sv
// Command/status bundle between the two angle requesters and the servo
// motion sequencer. The master side is the requester/observer; the slave
// side is the sequencer, which owns the readies and the driver angle.
interface servo_motion_ctrl_if;
    logic       req0_valid;
    logic [7:0] req0_angle;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_angle;
    logic       req1_ready;
    logic [7:0] angle_setting;
    logic       busy;
    logic       done;
    logic       grant_id;

    modport master (
        output req0_valid, req0_angle, req1_valid, req1_angle,
        input  req0_ready, req1_ready, angle_setting, busy, done, grant_id
    );

    modport slave (
        input  req0_valid, req0_angle, req1_valid, req1_angle,
        output req0_ready, req1_ready, angle_setting, busy, done, grant_id
    );
endinterface

// File: rtl/servo_motion_ctrl.sv
// Servo motion sequencer. Arbitrates between the vision tracker (req0) and
// the manual override (req1, higher priority), ramps the driver angle toward
// the granted target by at most STEP degrees per PWM frame, then settles for
// HOLD_FRAMES frames before the tracker may be granted again.
module servo_motion_ctrl #(
    parameter int unsigned FRAME_CYC   = 1_000_001,
    parameter int unsigned STEP        = 2,
    parameter int unsigned ANGLE_MIN   = 1,
    parameter int unsigned ANGLE_MAX   = 179,
    parameter int unsigned INIT_ANGLE  = 90,
    parameter int unsigned HOLD_FRAMES = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    servo_motion_ctrl_if.slave    bus
);

    localparam int unsigned CNT_W  = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 2);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [7:0]        A_MIN     = 8'(ANGLE_MIN);
    localparam logic [7:0]        A_MAX     = 8'(ANGLE_MAX);
    localparam logic [7:0]        A_INIT    = 8'(INIT_ANGLE);
    localparam logic [8:0]        STEP_9    = 9'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         angle_q, angle_d;
    logic [7:0]         target_q, target_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               done_q, done_d;
    logic               grant_q, grant_d;

    logic               tick_s;
    logic               req0_ready_s;
    logic               req1_ready_s;
    logic               busy_s;
    logic               acc0_s;
    logic               acc1_s;
    logic               accept_s;
    logic signed [8:0]  diff_s;
    logic [8:0]         mag_s;
    logic [7:0]         step_s;
    logic [7:0]         angle_next_s;
    logic [HOLD_W-1:0]  hold_inc_s;

    // Keep every commanded angle inside the range the driver actually pulses.
    function automatic logic [7:0] clamp_angle(input logic [7:0] a);
        logic [7:0] r;
        if (a < A_MIN) begin
            r = A_MIN;
        end else if (a > A_MAX) begin
            r = A_MAX;
        end else begin
            r = a;
        end
        return r;
    endfunction

    assign tick_s     = (cnt_q == CNT_LAST);
    assign acc0_s     = bus.req0_valid & req0_ready_s;
    assign acc1_s     = bus.req1_valid & req1_ready_s;
    assign accept_s   = acc0_s | acc1_s;
    assign hold_inc_s = hold_cnt_q + HOLD_ONE;

    // Output decode: readies and busy from state; readies held low during reset.
    always_comb begin
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;
        busy_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req1_ready_s = 1'b1;
                req0_ready_s = ~bus.req1_valid;
                busy_s       = 1'b0;
            end
            ST_MOVE, ST_HOLD: begin
                req1_ready_s = 1'b1;
                req0_ready_s = 1'b0;
                busy_s       = 1'b1;
            end
            default: begin
                req1_ready_s = 1'b0;
                req0_ready_s = 1'b0;
                busy_s       = 1'b0;
            end
        endcase
        if (!rst_n) begin
            req0_ready_s = 1'b0;
            req1_ready_s = 1'b0;
        end else begin
            req0_ready_s = req0_ready_s;
            req1_ready_s = req1_ready_s;
        end
    end

    // Next-state logic: an override accept always (re)enters MOVE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_MOVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (accept_s) begin
                    state_d = ST_MOVE;
                end else if (tick_s && (angle_q == target_q)) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_MOVE;
                end
            end
            ST_HOLD: begin
                if (accept_s) begin
                    state_d = ST_MOVE;
                end else if (tick_s && (hold_inc_s >= HOLD_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bounded step toward target: sign(diff) * min(STEP, |diff|), never overshoots.
    always_comb begin
        diff_s = $signed({1'b0, target_q}) - $signed({1'b0, angle_q});
        if (diff_s < 9'sd0) begin
            mag_s = $unsigned(-diff_s);
        end else begin
            mag_s = $unsigned(diff_s);
        end
        if (mag_s < STEP_9) begin
            step_s = mag_s[7:0];
        end else begin
            step_s = STEP_9[7:0];
        end
        if (diff_s < 9'sd0) begin
            angle_next_s = angle_q - step_s;
        end else begin
            angle_next_s = angle_q + step_s;
        end
    end

    // Free-running frame counter; a grant never restarts it.
    always_comb begin
        if (tick_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Datapath updates: accept loads target, MOVE steps/arrives on tick, HOLD counts ticks.
    always_comb begin
        angle_d    = angle_q;
        target_d   = target_q;
        grant_d    = grant_q;
        hold_cnt_d = hold_cnt_q;
        done_d     = 1'b0;
        if (accept_s) begin
            grant_d    = acc1_s;
            target_d   = acc1_s ? clamp_angle(bus.req1_angle) : clamp_angle(bus.req0_angle);
            hold_cnt_d = {HOLD_W{1'b0}};
        end else begin
            case (state_q)
                ST_MOVE: begin
                    if (tick_s) begin
                        if (angle_q == target_q) begin
                            done_d     = 1'b1;
                            hold_cnt_d = {HOLD_W{1'b0}};
                        end else begin
                            angle_d = angle_next_s;
                        end
                    end else begin
                        angle_d = angle_q;
                    end
                end
                ST_HOLD: begin
                    if (tick_s) begin
                        hold_cnt_d = hold_inc_s;
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                end
                default: begin
                    angle_d = angle_q;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset snaps the angle back to its parking position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= {CNT_W{1'b0}};
            angle_q    <= A_INIT;
            target_q   <= A_INIT;
            hold_cnt_q <= {HOLD_W{1'b0}};
            done_q     <= 1'b0;
            grant_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            angle_q    <= angle_d;
            target_q   <= target_d;
            hold_cnt_q <= hold_cnt_d;
            done_q     <= done_d;
            grant_q    <= grant_d;
        end
    end

    assign bus.req0_ready    = req0_ready_s;
    assign bus.req1_ready    = req1_ready_s;
    assign bus.angle_setting = angle_q;
    assign bus.busy          = busy_s;
    assign bus.done          = done_q;
    assign bus.grant_id      = grant_q;

endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Directed bench for servo_motion_ctrl with a 10-cycle frame, STEP=2, HOLD_FRAMES=2.
module tb_servo_motion_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    servo_motion_ctrl_if bus();

    servo_motion_ctrl #(
        .FRAME_CYC  (10),
        .STEP       (2),
        .ANGLE_MIN  (1),
        .ANGLE_MAX  (179),
        .INIT_ANGLE (90),
        .HOLD_FRAMES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Wait for the next angle change (bounded); cycles=-1 on timeout.
    task automatic wait_change(output logic [7:0] val, output int cycles, output bit saw_done);
        logic [7:0] prev;
        prev     = bus.angle_setting;
        val      = prev;
        cycles   = -1;
        saw_done = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
            if (bus.angle_setting !== prev) begin
                val    = bus.angle_setting;
                cycles = i;
                break;
            end
        end
    endtask

    // Wait for a done pulse (bounded), tracking the angle range seen on the way.
    task automatic wait_done(output int cycles, output logic [7:0] ang,
                             output logic [7:0] amin, output logic [7:0] amax);
        cycles = -1;
        ang    = 8'd0;
        amin   = 8'd255;
        amax   = 8'd0;
        for (int i = 1; i <= 1200; i++) begin
            @(negedge clk);
            if (bus.angle_setting < amin) amin = bus.angle_setting;
            if (bus.angle_setting > amax) amax = bus.angle_setting;
            if (bus.done === 1'b1) begin
                cycles = i;
                ang    = bus.angle_setting;
                break;
            end
        end
    endtask

    // Wait for busy to fall (bounded), counting done pulses meanwhile.
    task automatic wait_idle(output int cycles, output int dones);
        cycles = -1;
        dones  = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
            if (bus.busy === 1'b0) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Present a command on one requester until accepted; returns at the following negedge.
    task automatic send(input bit which, input logic [7:0] a, output bit ok);
        bit r;
        ok = 1'b0;
        if (which) begin
            bus.req1_valid = 1'b1;
            bus.req1_angle = a;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_angle = a;
        end
        for (int i = 0; i < 1000; i++) begin
            #1;
            r = which ? bus.req1_ready : bus.req0_ready;
            @(posedge clk);
            @(negedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (which) bus.req1_valid = 1'b0;
        else       bus.req0_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.req0_valid = 1'b0;
        bus.req0_angle = 8'd0;
        bus.req1_valid = 1'b0;
        bus.req1_angle = 8'd0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_readies: got r0=%b r1=%b, want 0 0", bus.req0_ready, bus.req1_ready);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.angle_setting !== 8'd90 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.grant_id !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got angle=%0d busy=%b done=%b gid=%b, want 90 0 0 0",
                     bus.angle_setting, bus.busy, bus.done, bus.grant_id);
        end
        vectors++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_readies: got r0=%b r1=%b, want 1 1", bus.req0_ready, bus.req1_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_basic_ramp();
        logic [7:0] exp_seq [3];
        logic [7:0] v, amin, amax, ang;
        int c, dones;
        bit sd, ok;
        exp_seq[0] = 8'd92; exp_seq[1] = 8'd94; exp_seq[2] = 8'd95;
        send(1'b0, 8'd95, ok);
        vectors++;
        if (ok !== 1'b1 || bus.grant_id !== 1'b0 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ramp_accept: got ok=%b gid=%b busy=%b, want 1 0 1", ok, bus.grant_id, bus.busy);
        end
        for (int k = 0; k < 3; k++) begin
            wait_change(v, c, sd);
            vectors++;
            if (v !== exp_seq[k] || sd || (k == 0 ? (c < 1 || c > 10) : (c != 10))) begin
                miscompares++;
                $display("FAIL ramp_step%0d: got angle=%0d after %0d cycles done_seen=%b, want %0d (one frame apart, no done)",
                         k, v, c, sd, exp_seq[k]);
            end
        end
        wait_done(c, ang, amin, amax);
        vectors++;
        if (c != 10 || ang !== 8'd95 || bus.grant_id !== 1'b0) begin
            miscompares++;
            $display("FAIL ramp_done: got %0d cycles angle=%0d gid=%b, want 10 95 0", c, ang, bus.grant_id);
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL ramp_done_width: got done=%b on next cycle, want 0", bus.done);
        end
        wait_idle(c, dones);
        vectors++;
        if (c != 19 || dones != 0) begin
            miscompares++;
            $display("FAIL ramp_hold: got idle after %0d cycles dones=%0d, want 19 0", c, dones);
        end
    endtask

    task automatic test_priority();
        logic [7:0] ang, amin, amax;
        int c, dones;
        bit ok;
        bus.req0_valid = 1'b1; bus.req0_angle = 8'd60;
        bus.req1_valid = 1'b1; bus.req1_angle = 8'd120;
        #1;
        vectors++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_readies: got r0=%b r1=%b, want 0 1", bus.req0_ready, bus.req1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        #1;
        vectors++;
        if (bus.grant_id !== 1'b1 || bus.busy !== 1'b1 || bus.req0_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_grant: got gid=%b busy=%b r0=%b, want 1 1 0", bus.grant_id, bus.busy, bus.req0_ready);
        end
        wait_done(c, ang, amin, amax);
        vectors++;
        if (c < 0 || ang !== 8'd120 || bus.grant_id !== 1'b1 || bus.req0_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_done: got %0d cycles angle=%0d gid=%b r0=%b, want arrival at 120 gid 1 r0 0",
                     c, ang, bus.grant_id, bus.req0_ready);
        end
        wait_idle(c, dones);
        #1;
        vectors++;
        if (c < 0 || bus.req0_ready !== 1'b1 || bus.grant_id !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_idle: got idle_cycles=%0d r0=%b gid=%b, want idle with r0 1 gid 1",
                     c, bus.req0_ready, bus.grant_id);
        end
        send(1'b0, 8'd60, ok);
        vectors++;
        if (ok !== 1'b1 || bus.grant_id !== 1'b0 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_late_accept: got ok=%b gid=%b busy=%b, want 1 0 1", ok, bus.grant_id, bus.busy);
        end
        wait_done(c, ang, amin, amax);
        vectors++;
        if (c < 0 || ang !== 8'd60) begin
            miscompares++;
            $display("FAIL prio_second_done: got %0d cycles angle=%0d, want arrival at 60", c, ang);
        end
        wait_idle(c, dones);
    endtask

    task automatic test_preempt();
        logic [7:0] v, ang, amin, amax;
        logic [7:0] exp_seq [5];
        int c, dones;
        bit sd, sawd, ok;
        exp_seq[0] = 8'd108; exp_seq[1] = 8'd106; exp_seq[2] = 8'd104;
        exp_seq[3] = 8'd102; exp_seq[4] = 8'd100;
        sawd = 1'b0;
        v    = 8'd0;
        send(1'b0, 8'd150, ok);
        for (int k = 0; k < 40; k++) begin
            wait_change(v, c, sd);
            if (sd) sawd = 1'b1;
            if (v == 8'd110 || c < 0) break;
        end
        vectors++;
        if (v !== 8'd110 || sawd) begin
            miscompares++;
            $display("FAIL preempt_reach110: got angle=%0d done_seen=%b, want 110 0", v, sawd);
        end
        send(1'b1, 8'd100, ok);
        vectors++;
        if (ok !== 1'b1 || bus.grant_id !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL preempt_accept: got ok=%b gid=%b done=%b, want 1 1 0", ok, bus.grant_id, bus.done);
        end
        for (int k = 0; k < 5; k++) begin
            wait_change(v, c, sd);
            vectors++;
            if (v !== exp_seq[k] || sd) begin
                miscompares++;
                $display("FAIL preempt_step%0d: got angle=%0d done_seen=%b, want %0d 0", k, v, sd, exp_seq[k]);
            end
        end
        wait_done(c, ang, amin, amax);
        vectors++;
        if (c != 10 || ang !== 8'd100 || bus.grant_id !== 1'b1) begin
            miscompares++;
            $display("FAIL preempt_done: got %0d cycles angle=%0d gid=%b, want 10 100 1", c, ang, bus.grant_id);
        end
        @(negedge clk);
        wait_idle(c, dones);
        vectors++;
        if (c < 0 || dones != 0) begin
            miscompares++;
            $display("FAIL preempt_single_done: got idle_cycles=%0d extra dones=%0d, want idle and 0", c, dones);
        end
    endtask

    task automatic test_clamp();
        logic [7:0] ang, amin, amax;
        int c, dones;
        bit ok;
        send(1'b0, 8'd0, ok);
        wait_done(c, ang, amin, amax);
        vectors++;
        if (c < 0 || ang !== 8'd1 || amin !== 8'd1 || bus.grant_id !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp_low: got angle=%0d min_seen=%0d gid=%b cycles=%0d, want 1 1 0", ang, amin, bus.grant_id, c);
        end
        wait_idle(c, dones);
        send(1'b1, 8'd200, ok);
        wait_done(c, ang, amin, amax);
        vectors++;
        if (c < 0 || ang !== 8'd179 || amax !== 8'd179 || bus.grant_id !== 1'b1) begin
            miscompares++;
            $display("FAIL clamp_high: got angle=%0d max_seen=%0d gid=%b cycles=%0d, want 179 179 1", ang, amax, bus.grant_id, c);
        end
        wait_idle(c, dones);
    endtask

    task automatic test_same_target_and_reset();
        logic [7:0] v, ang, amin, amax;
        int c, dones;
        bit sd, ok, bad;
        // Single odd step down, so the next ramp lands on even angles.
        send(1'b0, 8'd178, ok);
        wait_done(c, ang, amin, amax);
        vectors++;
        if (c < 0 || ang !== 8'd178) begin
            miscompares++;
            $display("FAIL odd_step: got angle=%0d cycles=%0d, want 178", ang, c);
        end
        wait_idle(c, dones);
        send(1'b0, 8'd40, ok);
        v = 8'd0;
        for (int k = 0; k < 70; k++) begin
            wait_change(v, c, sd);
            if (v == 8'd70 || c < 0) break;
        end
        vectors++;
        if (v !== 8'd70) begin
            miscompares++;
            $display("FAIL reset_reach70: got angle=%0d, want 70", v);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.angle_setting !== 8'd90 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midmove_reset: got angle=%0d busy=%b done=%b r0=%b r1=%b, want 90 0 0 0 0",
                     bus.angle_setting, bus.busy, bus.done, bus.req0_ready, bus.req1_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.angle_setting !== 8'd90 || bus.busy !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad || bus.req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL after_reset_quiet: got disturbance=%b r0=%b angle=%0d, want 0 1 90", bad, bus.req0_ready, bus.angle_setting);
        end
        send(1'b0, 8'd90, ok);
        wait_done(c, ang, amin, amax);
        vectors++;
        if (c < 1 || c > 10 || ang !== 8'd90 || amin !== 8'd90 || amax !== 8'd90) begin
            miscompares++;
            $display("FAIL same_target: got %0d cycles angle=%0d range=%0d..%0d, want done within a frame at 90",
                     c, ang, amin, amax);
        end
        wait_idle(c, dones);
        vectors++;
        if (c < 0 || dones != 0) begin
            miscompares++;
            $display("FAIL same_target_idle: got idle_cycles=%0d dones=%0d, want idle and 0", c, dones);
        end
    endtask

    initial begin
        test_reset();
        test_basic_ramp();
        test_priority();
        test_preempt();
        test_clamp();
        test_same_target_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
